tlb_mem_responder: RTL and testbench
====================================

Name: tlb_mem_responder

Overview:
- Memory-side responder for the TLB page-walk / fill memory port (mem_paddr, mem_req, mem_read, mem_write_value, mem_ack, mem_read_value).
- Services one word read or write per four-phase req/ack handshake.
- Data is held in an on-chip word-addressed RAM.
- Adds a programmable response latency and an out-of-range error flag, so the TLB walker is exercised against a realistic, non-combinational memory.

Parameters:
- PADDR_W, 26, physical byte-address width; matches the TLB mem_paddr width.
- DEPTH_LOG2, 24, log2 of the RAM depth in 32-bit words. Default covers the full 64 MB.
- LATENCY, 2, cycles from the req-sampled edge to the ack-assert edge. Legal range 1..15.

Ports:
- clk  in  1  clock, all state on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_paddr  in  PADDR_W  byte address; bits [1:0] ignored
- mem_req  in  1  request, level, held until ack is seen
- mem_read  in  1  1 = read, 0 = write; sampled with req
- mem_write_value  in  32  write data; sampled with req
- mem_ack  out  1  acknowledge
- mem_read_value  out  32  read data, valid while mem_ack = 1
- mem_err  out  1  one-cycle pulse coincident with the ack of an out-of-range access

Behaviour:
- Reset (async assert, sync release):
  - mem_ack = 0, mem_err = 0, mem_read_value = 0, state = IDLE, latency counter = 0.
  - RAM contents are not cleared.
- Word index = mem_paddr[PADDR_W-1:2]. An access is out-of-range when any index bit at or above DEPTH_LOG2 is set.
- State IDLE:
  - On a rising edge with mem_req = 1, capture address, read flag and write data.
  - Load counter = LATENCY-1 and go to WAIT.
- State WAIT:
  - Counter decrements each edge.
  - If mem_req = 0 on any WAIT edge (abort), go to IDLE. No ack, no write, no err.
  - When counter = 0 and mem_req = 1:
    - perform the access;
    - assert mem_ack;
    - go to ACK.
  - Result: ack rises exactly LATENCY edges after the req-sampled edge.
- Access rules:
  - Read: mem_read_value <= RAM[index], or 0 if out-of-range. Registered; stable for the whole ACK state.
  - Write: RAM[index] <= captured data on the ack-assert edge. Out-of-range writes are dropped.
  - mem_read_value is unchanged by writes and holds its last value outside ACK.
  - mem_err = 1 for exactly the ack-assert cycle of an out-of-range access.
- State ACK:
  - mem_ack stays 1 while mem_req = 1.
  - The first edge with mem_req = 0 clears mem_ack and returns to IDLE.
  - A new request is accepted no earlier than the edge after ack falls, so there is no back-to-back overlap.
- Inputs changing during WAIT or ACK while req stays high: ignored, because the captured values are used.
- Reset mid-WAIT: the pending write is discarded.
- Reset mid-ACK: ack drops asynchronously; any write already committed stays.
- Throughput: one transaction per LATENCY+2 cycles at best.

Decomposition:
- Shared package tlb_mem_pkg:
  - PADDR_W and word-width localparams;
  - state encoding (IDLE, WAIT, ACK) as 2-bit constants;
  - PTE bit-position constants (P = 0, W = 1, S = 2, PS = 7, X) shared with tlb.
- Sub-module tlb_mem_ram: single-port synchronous RAM (addr, we, wdata, rdata registered, 1-cycle read).
  - The responder issues the RAM read on the edge before ack so read data is registered on the ack edge. The responder owns all handshake logic.

Test Plan:
- Reset, then preload RAM['h3000000/4] = 'h3001007 by the bench backdoor. Read 'h3000000 with LATENCY = 2 -> mem_ack rises 2 edges after the req edge, mem_read_value = 'h3001007, mem_err = 0.
- Write 'hfeedbeef to 'h000e000, release req, then read 'h000e003 -> read returns 'hfeedbeef (low bits ignored).
- DEPTH_LOG2 = 12: read 'h3000000 -> ack with mem_read_value = 0 and a one-cycle mem_err. Write 'h12345678 to 'h4000 (index 'h1000) -> err pulse; reading index 0 still returns its prior value.
- Abort: req high 1 cycle with LATENCY = 3, write 'hdeadbeef to 'h10 -> no ack, RAM['h10/4] unchanged.
- Assert rst asynchronously mid-ACK -> mem_ack = 0 within the same cycle, state IDLE. The next read completes normally.
- Connect to tlb, vaddr 'h4000, dirpf 'h3000, page tables as in the system bench -> hit = 1, read_out = 'hfeedbeef. vaddr 'h4f1234 -> 'hdef5a1ad via the large page.

Source files
------------

// File: rtl/tlb_mem_pkg.sv
// ---------------------------------------------------------------------------
// tlb_mem_pkg
// Shared definitions for the TLB memory port and its memory-side responder:
//   - address/word widths of the TLB memory port
//   - responder handshake state encoding
//   - PTE bit positions shared with the TLB page walker
// ---------------------------------------------------------------------------
package tlb_mem_pkg;

    // Physical byte-address width seen on the TLB memory port
    localparam int TLB_PADDR_W = 26;

    // Every access moves one 32-bit word
    localparam int WORD_W = 32;

    // Wide enough for any response latency from 1 to 15
    localparam int LAT_CNT_W = 4;

    // Responder handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } mem_state_e;

    // PTE bit positions, kept here so the walker and the memory model agree
    localparam int PTE_P  = 0;
    localparam int PTE_W  = 1;
    localparam int PTE_S  = 2;
    localparam int PTE_X  = 3;
    localparam int PTE_PS = 7;

endpackage

// File: rtl/tlb_mem_responder_if.sv
// ---------------------------------------------------------------------------
// tlb_mem_responder_if
// Four-phase req/ack memory port between the TLB walker (master) and the
// memory responder (slave).
//   mem_paddr        byte address, bits [1:0] ignored
//   mem_req          request level, held until ack is seen
//   mem_read         1 = read, 0 = write
//   mem_write_value  write data
//   mem_ack          acknowledge
//   mem_read_value   read data, valid while mem_ack is high
//   mem_err          one-cycle pulse with the ack of an out-of-range access
// ---------------------------------------------------------------------------
interface tlb_mem_responder_if
    import tlb_mem_pkg::*;
#(
    parameter int PADDR_W = TLB_PADDR_W
);

    logic [PADDR_W-1:0] mem_paddr;
    logic               mem_req;
    logic               mem_read;
    logic [WORD_W-1:0]  mem_write_value;
    logic               mem_ack;
    logic [WORD_W-1:0]  mem_read_value;
    logic               mem_err;

    modport master (
        output mem_paddr, mem_req, mem_read, mem_write_value,
        input  mem_ack, mem_read_value, mem_err
    );

    modport slave (
        input  mem_paddr, mem_req, mem_read, mem_write_value,
        output mem_ack, mem_read_value, mem_err
    );

endinterface

// File: rtl/tlb_mem_ram.sv
// ---------------------------------------------------------------------------
// tlb_mem_ram
// Single-port synchronous word RAM with a registered, one-cycle read.
//   clk      clock
//   rst      async active-high reset (clears only the read register)
//   addr_i   word address
//   we_i     write enable, wdata_i stored at addr_i on the rising edge
//   re_i     read enable, rdata_o updated from addr_i on the rising edge
//   wdata_i  write data
//   rdata_o  registered read data, holds its value when re_i is low
// ---------------------------------------------------------------------------
module tlb_mem_ram
    import tlb_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage array: never reset, so contents survive a responder reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register: only moves on an enabled read so the last result is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tlb_mem_responder.sv
// ---------------------------------------------------------------------------
// tlb_mem_responder
// Memory-side responder for the TLB page-walk / fill port. Services one word
// read or write per four-phase req/ack handshake, after a programmable
// latency, from an on-chip word-addressed RAM. Accesses whose word index has
// any bit set at or above DEPTH_LOG2 are out-of-range: reads return 0, writes
// are dropped, and mem_err pulses together with the ack.
//   clk  clock
//   rst  async active-high reset
//   bus  slave side of tlb_mem_responder_if
// Parameters:
//   PADDR_W     byte-address width
//   DEPTH_LOG2  log2 of RAM depth in 32-bit words
//   LATENCY     edges from req-sampled edge to ack-assert edge (1..15)
// ---------------------------------------------------------------------------
module tlb_mem_responder
    import tlb_mem_pkg::*;
#(
    parameter int PADDR_W    = TLB_PADDR_W,
    parameter int DEPTH_LOG2 = 24,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    tlb_mem_responder_if.slave bus
);

    localparam int IDX_W = PADDR_W - 2;

    mem_state_e           state_q;
    logic [LAT_CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0]     addrIdx_q;
    logic                 isRead_q;
    logic                 outOfRange_q;
    logic [WORD_W-1:0]    wrData_q;
    logic                 ack_q;
    logic                 err_q;
    logic                 zeroRead_q;

    logic [IDX_W-1:0]      reqIdx;
    logic                  reqOutOfRange;
    logic                  fire;
    logic                  ramWe;
    logic                  ramRe;
    logic [DEPTH_LOG2-1:0] ramAddr;
    logic [WORD_W-1:0]     ramRdata;
    logic                  unusedAddrBits;

    // Word index and range test of the address currently on the bus; both are
    // only used at the capture edge in IDLE
    assign reqIdx         = bus.mem_paddr[PADDR_W-1:2];
    assign reqOutOfRange  = (reqIdx >> DEPTH_LOG2) != '0;
    assign unusedAddrBits = ^bus.mem_paddr[1:0];

    // The access edge: last WAIT edge with req still held. The RAM is driven
    // from the captured request during the cycle before this edge, so the
    // registered read data lands exactly on the ack-assert edge.
    assign fire    = (state_q == ST_WAIT) && bus.mem_req && (cnt_q == '0);
    assign ramWe   = fire && !isRead_q && !outOfRange_q;
    assign ramRe   = fire && isRead_q && !outOfRange_q;
    assign ramAddr = DEPTH_LOG2'(addrIdx_q);

    tlb_mem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (ramAddr),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .wdata_i (wrData_q),
        .rdata_o (ramRdata)
    );

    // Handshake FSM. IDLE captures the request and loads the latency counter,
    // WAIT counts down (dropping req aborts with no side effects), ACK holds
    // ack until req falls. err is a single-cycle pulse, so it is cleared by
    // default every edge and only set on the ack-assert edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addrIdx_q    <= '0;
            isRead_q     <= 1'b0;
            outOfRange_q <= 1'b0;
            wrData_q     <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            zeroRead_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        addrIdx_q    <= reqIdx;
                        isRead_q     <= bus.mem_read;
                        outOfRange_q <= reqOutOfRange;
                        wrData_q     <= bus.mem_write_value;
                        cnt_q        <= LAT_CNT_W'(LATENCY - 1);
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.mem_req) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        err_q   <= outOfRange_q;
                        state_q <= ST_ACK;
                        // An out-of-range read reports 0 until the next read
                        if (isRead_q) begin
                            zeroRead_q <= outOfRange_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!bus.mem_req) begin
                        ack_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ack        = ack_q;
    assign bus.mem_err        = err_q;
    assign bus.mem_read_value = zeroRead_q ? '0 : ramRdata;

endmodule

// File: tb/tb_tlb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_tlb_mem_responder
// Drives two responders (full 64 MB depth with latency 2, and a 4K-word
// instance with latency 3) through fixed vectors, multi-cycle corner cases
// and random traffic, comparing against a word-level memory model.
// ---------------------------------------------------------------------------
module tb_tlb_mem_responder;

    localparam int PW      = 26;
    localparam int LAT_A   = 2;
    localparam int LAT_B   = 3;
    localparam int DEPTH_A = 24;
    localparam int DEPTH_B = 12;

    typedef struct {
        int          which;
        logic        rd;
        logic [25:0] addr;
        logic [31:0] wd;
        int          hold;
        logic        expErr;
        logic [31:0] expRv;
    } tableVec_t;

    logic clk = 1'b0;
    logic rst;

    int nChecks = 0;
    int nFails  = 0;

    // Word-level model: one sparse memory per instance plus the value each
    // instance should currently present on mem_read_value
    logic [31:0] memA [int];
    logic [31:0] memB [int];
    logic [31:0] lastRead [2];
    bit          lastKnown [2];

    always #5 clk = ~clk;

    tlb_mem_responder_if #(.PADDR_W(PW)) busA();
    tlb_mem_responder_if #(.PADDR_W(PW)) busB();

    tlb_mem_responder #(
        .PADDR_W    (PW),
        .DEPTH_LOG2 (DEPTH_A),
        .LATENCY    (LAT_A)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    tlb_mem_responder #(
        .PADDR_W    (PW),
        .DEPTH_LOG2 (DEPTH_B),
        .LATENCY    (LAT_B)
    ) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    // Compare one value and log a failure line if it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 'h%08h, expected 'h%08h", name, act, exp);
        end
    endtask

    task automatic setIn(input int which, input logic req, input logic rd,
                         input logic [25:0] addr, input logic [31:0] wd);
        if (which == 0) begin
            busA.mem_req = req; busA.mem_read = rd;
            busA.mem_paddr = addr; busA.mem_write_value = wd;
        end else begin
            busB.mem_req = req; busB.mem_read = rd;
            busB.mem_paddr = addr; busB.mem_write_value = wd;
        end
    endtask

    task automatic getOut(input int which, output logic ack, output logic [31:0] rv, output logic err);
        if (which == 0) begin
            ack = busA.mem_ack; rv = busA.mem_read_value; err = busA.mem_err;
        end else begin
            ack = busB.mem_ack; rv = busB.mem_read_value; err = busB.mem_err;
        end
    endtask

    function automatic void modelReset();
        lastRead[0] = '0; lastRead[1] = '0;
        lastKnown[0] = 1'b1; lastKnown[1] = 1'b1;
    endfunction

    // Apply one access to the model: returns whether it is out of range and
    // updates the model memory / presented read value
    function automatic void modelAccess(input int which, input logic rd, input logic [25:0] addr,
                                        input logic [31:0] wd, output logic expErr);
        int idx;
        int depthWords;
        idx        = int'(addr[25:2]);
        depthWords = (which == 0) ? (1 << DEPTH_A) : (1 << DEPTH_B);
        expErr     = (idx >= depthWords);
        if (rd) begin
            if (expErr) begin
                lastRead[which] = '0; lastKnown[which] = 1'b1;
            end else if (which == 0 && memA.exists(idx)) begin
                lastRead[which] = memA[idx]; lastKnown[which] = 1'b1;
            end else if (which == 1 && memB.exists(idx)) begin
                lastRead[which] = memB[idx]; lastKnown[which] = 1'b1;
            end else begin
                lastKnown[which] = 1'b0;
            end
        end else if (!expErr) begin
            if (which == 0) memA[idx] = wd;
            else            memB[idx] = wd;
        end
    endfunction

    // One complete handshake starting at a negedge. Inputs are scrambled after
    // the req-sampled edge to show the captured request is what gets served.
    task automatic applyStimulus(input int which, input logic rd, input logic [25:0] addr,
                                 input logic [31:0] wd, input int hold, input logic expErr,
                                 input logic [31:0] expRv, input bit rvKnown, input string tag);
        logic ack, err;
        logic [31:0] rv, firstRv;
        int edges, expLat;
        bit gotAck;
        expLat = (which == 0) ? LAT_A : LAT_B;
        setIn(which, 1'b1, rd, addr, wd);
        edges = 0; gotAck = 0; ack = 0; err = 0; rv = '0;
        while (!gotAck && edges < 40) begin
            @(negedge clk);
            edges++;
            if (edges == 1) setIn(which, 1'b1, ~rd, ~addr, ~wd);
            getOut(which, ack, rv, err);
            if (ack) gotAck = 1;
        end
        checkOutput({tag, " ackLatency"}, 32'(edges - 1), 32'(expLat));
        if (gotAck) begin
            checkOutput({tag, " errOnAck"}, {31'b0, err}, {31'b0, expErr});
            if (rvKnown) checkOutput({tag, " readValue"}, rv, expRv);
            firstRv = rv;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                getOut(which, ack, rv, err);
                checkOutput({tag, " ackHeld"}, {31'b0, ack}, 32'd1);
                checkOutput({tag, " errPulseEnded"}, {31'b0, err}, 32'd0);
                checkOutput({tag, " readStable"}, rv, firstRv);
            end
        end
        setIn(which, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        getOut(which, ack, rv, err);
        checkOutput({tag, " ackDropped"}, {31'b0, ack}, 32'd0);
        checkOutput({tag, " errLow"}, {31'b0, err}, 32'd0);
    endtask

    // Handshake whose expectations come from the model
    task automatic doModelTxn(input int which, input logic rd, input logic [25:0] addr,
                              input logic [31:0] wd, input int hold, input string tag);
        logic expErr;
        modelAccess(which, rd, addr, wd, expErr);
        applyStimulus(which, rd, addr, wd, hold, expErr, lastRead[which], lastKnown[which], tag);
    endtask

    // Watchdog so a stuck handshake cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tableVec_t vecs[12];
        logic ack, err, dummyErr;
        logic [31:0] rv;
        int edges;
        bit gotAck, ackSeen, errSeen;

        vecs[0]  = '{0, 1'b0, 26'h3000000, 32'h03001007, 1, 1'b0, 32'h00000000};
        vecs[1]  = '{0, 1'b1, 26'h3000000, 32'h00000000, 2, 1'b0, 32'h03001007};
        vecs[2]  = '{0, 1'b0, 26'h000e000, 32'hfeedbeef, 1, 1'b0, 32'h03001007};
        vecs[3]  = '{0, 1'b1, 26'h000e003, 32'h00000000, 1, 1'b0, 32'hfeedbeef};
        vecs[4]  = '{1, 1'b0, 26'h0000000, 32'hcafef00d, 1, 1'b0, 32'h00000000};
        vecs[5]  = '{1, 1'b1, 26'h3000000, 32'h00000000, 2, 1'b1, 32'h00000000};
        vecs[6]  = '{1, 1'b0, 26'h0004000, 32'h12345678, 1, 1'b1, 32'h00000000};
        vecs[7]  = '{1, 1'b1, 26'h0000000, 32'h00000000, 1, 1'b0, 32'hcafef00d};
        vecs[8]  = '{1, 1'b0, 26'h0003ffc, 32'h0badcafe, 1, 1'b0, 32'hcafef00d};
        vecs[9]  = '{1, 1'b1, 26'h0003ffe, 32'h00000000, 1, 1'b0, 32'h0badcafe};
        vecs[10] = '{1, 1'b1, 26'h0004000, 32'h00000000, 1, 1'b1, 32'h00000000};
        vecs[11] = '{0, 1'b1, 26'h000e000, 32'h00000000, 3, 1'b0, 32'hfeedbeef};

        rst = 1'b1;
        setIn(0, 1'b0, 1'b0, '0, '0);
        setIn(1, 1'b0, 1'b0, '0, '0);
        modelReset();
        repeat (3) @(negedge clk);

        // Outputs while reset is held
        for (int w = 0; w < 2; w++) begin
            getOut(w, ack, rv, err);
            checkOutput($sformatf("reset%0d ack", w), {31'b0, ack}, 32'd0);
            checkOutput($sformatf("reset%0d err", w), {31'b0, err}, 32'd0);
            checkOutput($sformatf("reset%0d readValue", w), rv, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Fixed vectors; the model is kept in step so later phases can use it
        for (int i = 0; i < 12; i++) begin
            modelAccess(vecs[i].which, vecs[i].rd, vecs[i].addr, vecs[i].wd, dummyErr);
            applyStimulus(vecs[i].which, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].hold,
                          vecs[i].expErr, vecs[i].expRv, 1'b1, $sformatf("vec%0d", i));
        end

        // Abort: req held for a single edge never produces ack or a write
        doModelTxn(1, 1'b0, 26'h10, 32'h55aa55aa, 1, "preAbort");
        setIn(1, 1'b1, 1'b0, 26'h10, 32'hdeadbeef);
        @(negedge clk);
        setIn(1, 1'b0, 1'b0, '0, '0);
        ackSeen = 0; errSeen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            getOut(1, ack, rv, err);
            if (ack) ackSeen = 1;
            if (err) errSeen = 1;
        end
        checkOutput("abort noAck", {31'b0, ackSeen}, 32'd0);
        checkOutput("abort noErr", {31'b0, errSeen}, 32'd0);
        doModelTxn(1, 1'b1, 26'h10, '0, 1, "afterAbort");

        // Reset during WAIT discards the pending write
        doModelTxn(0, 1'b0, 26'h20, 32'haaaa0001, 1, "preWaitRst");
        setIn(0, 1'b1, 1'b0, 26'h20, 32'hbbbb0002);
        @(negedge clk);
        rst = 1'b1;
        #1;
        getOut(0, ack, rv, err);
        checkOutput("waitRst ack", {31'b0, ack}, 32'd0);
        setIn(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        doModelTxn(0, 1'b1, 26'h20, '0, 1, "afterWaitRst");

        // Reset during ACK drops ack asynchronously; next access is normal
        setIn(0, 1'b1, 1'b1, 26'h3000000, '0);
        edges = 0; gotAck = 0;
        while (!gotAck && edges < 40) begin
            @(negedge clk);
            edges++;
            getOut(0, ack, rv, err);
            if (ack) gotAck = 1;
        end
        checkOutput("ackRst ackBefore", {31'b0, gotAck}, 32'd1);
        checkOutput("ackRst readBefore", rv, 32'h03001007);
        #2;
        rst = 1'b1;
        #1;
        getOut(0, ack, rv, err);
        checkOutput("ackRst ackAsync", {31'b0, ack}, 32'd0);
        checkOutput("ackRst readCleared", rv, 32'd0);
        setIn(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        doModelTxn(0, 1'b1, 26'h3000000, '0, 1, "afterAckRst");

        // Random traffic on both instances against the model
        for (int n = 0; n < 40; n++) begin
            int which;
            logic rd;
            logic [23:0] idx;
            logic [25:0] addr;
            bit inRange;
            which = n % 2;
            if (which == 0) begin
                idx = 24'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 24'hc00000 : 24'h0);
                inRange = 1;
            end else if ($urandom_range(0, 2) == 0) begin
                idx = 24'h001000 | 24'($urandom);
                inRange = 0;
            end else begin
                idx = 24'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 24'h000ff0 : 24'h0);
                inRange = 1;
            end
            addr = {idx, 2'($urandom_range(0, 3))};
            rd = ($urandom_range(0, 1) != 0);
            // Reads go only to words the model knows, or out of range
            if (rd && inRange) begin
                if (which == 0 && !memA.exists(int'(idx))) rd = 1'b0;
                if (which == 1 && !memB.exists(int'(idx))) rd = 1'b0;
            end
            doModelTxn(which, rd, addr, $urandom, $urandom_range(1, 3), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
